// File: rtl/pdm_pkg.sv
// Shared constants and helpers for the PDM receive path (CIC order-2 decimator).
package pdm_pkg;

  localparam int NBITS_DEF      = 10;
  localparam int LOG2_DECIM_DEF = 5;

  function automatic int cic_width(input int log2_decim);
    return 2 * log2_decim + 1;
  endfunction

  // The only value that does not fit the output range is exact full scale.
  function automatic logic [31:0] sat_full(input logic [31:0] value, input int log2_decim);
    logic [31:0] full;
    full = 32'd1 << (2 * log2_decim);
    return (value == full) ? full - 32'd1 : value;
  endfunction

endpackage

// File: rtl/pdm_sync2.sv
// Two-flop synchronizer with asynchronous clear.
module pdm_sync2 (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic s1_d, s1_q;
  logic s2_d, s2_q;

  always_comb begin
    s1_d = d;
    s2_d = s1_q;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_q <= 1'b0;
      s2_q <= 1'b0;
    end else begin
      s1_q <= s1_d;
      s2_q <= s2_d;
    end
  end

  assign q = s2_q;

endmodule

// File: rtl/pdm_demod.sv
// PDM bit stream to NBITS-wide samples: order-2 CIC, decimation by 2**LOG2_DECIM.
module pdm_demod
  import pdm_pkg::*;
#(
  parameter int NBITS      = NBITS_DEF,
  parameter int LOG2_DECIM = LOG2_DECIM_DEF,
  parameter int SYNC       = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             pdm_in,
  input  logic             in_valid,
  output logic [NBITS-1:0] sample,
  output logic             sample_valid,
  output logic             settled
);

  localparam int W     = cic_width(LOG2_DECIM);
  localparam int SHIFT = 2 * LOG2_DECIM - NBITS;

  logic bit_p0;
  logic vld_p0;

  generate
    if (SYNC != 0) begin : g_sync
      pdm_sync2 u_sync_bit (.clk(clk), .rst(rst), .d(pdm_in),   .q(bit_p0));
      pdm_sync2 u_sync_vld (.clk(clk), .rst(rst), .d(in_valid), .q(vld_p0));
    end else begin : g_bypass
      assign bit_p0 = pdm_in;
      assign vld_p0 = in_valid;
    end
  endgenerate

  logic [LOG2_DECIM-1:0] cnt_d, cnt_q;
  logic [W-1:0]          i1_d, i1_q;
  logic [W-1:0]          i2_d, i2_q;
  logic                  vld_p1_d, vld_p1_q;
  logic [W-1:0]          i2_dly_d, i2_dly_q;
  logic [W-1:0]          c1_d, c1_q;
  logic                  vld_p2_d, vld_p2_q;
  logic [W-1:0]          c1_dly_d, c1_dly_q;
  logic [W-1:0]          c2_p2;
  logic [W-1:0]          c2_sat_p2;
  logic [NBITS-1:0]      sample_d, sample_q;
  logic                  sample_valid_d, sample_valid_q;
  logic                  first_d, first_q;
  logic                  settled_d, settled_q;

  // Stage 1: integrators and phase counter, advanced only by accepted bits
  always_comb begin
    i1_d     = i1_q;
    i2_d     = i2_q;
    cnt_d    = cnt_q;
    vld_p1_d = 1'b0;
    if (vld_p0) begin
      i1_d     = i1_q + W'(bit_p0);
      i2_d     = i2_q + i1_d;
      cnt_d    = cnt_q + LOG2_DECIM'(1);
      vld_p1_d = (cnt_q == '1);
    end
  end

  // Stage 2: decimate and first comb; i2_q still holds the window-closing value
  always_comb begin
    c1_d     = c1_q;
    i2_dly_d = i2_dly_q;
    vld_p2_d = vld_p1_q;
    if (vld_p1_q) begin
      c1_d     = i2_q - i2_dly_q;
      i2_dly_d = i2_q;
    end
  end

  // Stage 3: second comb, saturation, scaling and the output register
  assign c2_p2     = c1_q - c1_dly_q;
  assign c2_sat_p2 = W'(sat_full(32'(c2_p2), LOG2_DECIM));

  always_comb begin
    c1_dly_d       = c1_dly_q;
    sample_d       = sample_q;
    sample_valid_d = vld_p2_q;
    first_d        = first_q;
    settled_d      = settled_q;
    if (vld_p2_q) begin
      c1_dly_d  = c1_q;
      sample_d  = NBITS'(c2_sat_p2 >> SHIFT);
      first_d   = 1'b1;
      settled_d = settled_q | first_q;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q          <= '0;
      i1_q           <= '0;
      i2_q           <= '0;
      vld_p1_q       <= 1'b0;
      i2_dly_q       <= '0;
      c1_q           <= '0;
      vld_p2_q       <= 1'b0;
      c1_dly_q       <= '0;
      sample_q       <= '0;
      sample_valid_q <= 1'b0;
      first_q        <= 1'b0;
      settled_q      <= 1'b0;
    end else begin
      cnt_q          <= cnt_d;
      i1_q           <= i1_d;
      i2_q           <= i2_d;
      vld_p1_q       <= vld_p1_d;
      i2_dly_q       <= i2_dly_d;
      c1_q           <= c1_d;
      vld_p2_q       <= vld_p2_d;
      c1_dly_q       <= c1_dly_d;
      sample_q       <= sample_d;
      sample_valid_q <= sample_valid_d;
      first_q        <= first_d;
      settled_q      <= settled_d;
    end
  end

  assign sample       = sample_q;
  assign sample_valid = sample_valid_q;
  assign settled      = settled_q;

endmodule

// File: tb/tb_pdm_demod.sv
// Scoreboard bench: a triangle-window reference model predicts every strobe for a
// synchronized (SYNC=1) and a bypassed (SYNC=0) instance fed with the same stream.
module tb_pdm_demod;

  localparam int NBITS = 10;
  localparam int L     = 5;
  localparam int R     = 1 << L;
  localparam int SHIFT = 2 * L - NBITS;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic pdm_in = 1'b0;
  logic in_valid = 1'b0;
  logic [NBITS-1:0] smp [2];
  logic sv [2];
  logic st [2];

  pdm_demod #(.NBITS(NBITS), .LOG2_DECIM(L), .SYNC(1)) u_dut_sync (
    .clk(clk), .rst(rst), .pdm_in(pdm_in), .in_valid(in_valid),
    .sample(smp[0]), .sample_valid(sv[0]), .settled(st[0]));

  pdm_demod #(.NBITS(NBITS), .LOG2_DECIM(L), .SYNC(0)) u_dut_bypass (
    .clk(clk), .rst(rst), .pdm_in(pdm_in), .in_valid(in_valid),
    .sample(smp[1]), .sample_valid(sv[1]), .settled(st[1]));

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int val;
    int cyc;
    int settled;
  } exp_t;

  exp_t q [2][$];
  int   last_val [2];
  int   last_st [2];
  int   hist [$];
  int   nbits = 0;
  int   nstrobe = 0;
  int   checks = 0;
  int   passes = 0;
  int   latency [2] = '{5, 3};

  task automatic check(input string name, input int act, input int req);
    checks++;
    if (act == req) passes++;
    else $display("FAIL %s: got %0d, required %0d (cycle %0d)", name, act, req, cyc);
  endtask

  // Order-2 CIC == triangle FIR of length 2R-1 over the accepted-bit history
  function automatic int model_sample();
    int n, acc, h;
    n = hist.size();
    acc = 0;
    for (int m = 0; m < 2 * R - 1; m++) begin
      h = (m < R) ? m + 1 : 2 * R - 1 - m;
      if (m < n) acc += h * hist[n - 1 - m];
    end
    if (acc == R * R) acc = R * R - 1;
    return acc >> SHIFT;
  endfunction

  task automatic drive(input bit v, input bit b);
    exp_t e;
    @(posedge clk);
    #1;
    in_valid = v;
    pdm_in = b;
    if (v) begin
      hist.push_back(int'(b));
      if (hist.size() > 2 * R - 1) void'(hist.pop_front());
      nbits++;
      if (nbits % R == 0) begin
        nstrobe++;
        e.val = model_sample();
        e.settled = (nstrobe >= 2) ? 1 : 0;
        for (int k = 0; k < 2; k++) begin
          e.cyc = cyc + latency[k];
          q[k].push_back(e);
        end
      end
    end
  endtask

  task automatic idle(input int n);
    repeat (n) drive(1'b0, 1'b0);
  endtask

  task automatic do_reset(input int n);
    @(posedge clk);
    #1;
    rst = 1'b1;
    hist.delete();
    nbits = 0;
    nstrobe = 0;
    for (int k = 0; k < 2; k++) begin
      q[k].delete();
      last_val[k] = 0;
      last_st[k] = 0;
    end
    repeat (n) begin
      @(posedge clk);
      #1;
      pdm_in = 1'($urandom);
      in_valid = 1'($urandom);
    end
    @(posedge clk);
    #1;
    rst = 1'b0;
    in_valid = 1'b0;
  endtask

  always @(negedge clk) begin
    exp_t e;
    for (int k = 0; k < 2; k++) begin
      if (rst) begin
        check($sformatf("reset_outputs_%0d", k), int'({smp[k], sv[k], st[k]}), 0);
      end else begin
        while (q[k].size() > 0 && q[k][0].cyc < cyc) begin
          check($sformatf("missed_strobe_%0d", k), cyc, q[k][0].cyc);
          void'(q[k].pop_front());
        end
        if (sv[k]) begin
          if (q[k].size() == 0) begin
            check($sformatf("unexpected_strobe_%0d", k), 1, 0);
          end else begin
            e = q[k].pop_front();
            check($sformatf("sample_%0d", k), int'(smp[k]), e.val);
            check($sformatf("strobe_cycle_%0d", k), cyc, e.cyc);
            check($sformatf("settled_at_strobe_%0d", k), int'(st[k]), e.settled);
            last_val[k] = e.val;
            last_st[k] = e.settled;
          end
        end else begin
          check($sformatf("sample_hold_%0d", k), int'(smp[k]), last_val[k]);
          check($sformatf("settled_hold_%0d", k), int'(st[k]), last_st[k]);
        end
      end
    end
  end

  initial begin
    int acc;
    bit b;

    do_reset(6);
    repeat (200) drive(1'b1, 1'b0);
    idle(8);

    do_reset(2);
    repeat (128) drive(1'b1, 1'b1);
    idle(8);

    for (int ph = 0; ph < 2; ph++) begin
      do_reset(2);
      for (int i = 0; i < 128; i++) drive(1'b1, 1'((i + ph) % 2 == 0));
      idle(8);
    end

    do_reset(2);
    for (int i = 0; i < 256; i++) drive(1'(i % 2 == 0), 1'((i / 2) % 2 == 0));
    idle(8);

    do_reset(2);
    repeat (300) drive(1'($urandom_range(0, 3) != 0), 1'($urandom));
    idle(8);

    // First-order sigma-delta source standing in for the on-chip modulator
    do_reset(2);
    acc = 0;
    for (int i = 0; i < 16 * R; i++) begin
      acc += (i < 8 * R) ? 300 : 700;
      b = (acc >= 1024);
      if (b) acc -= 1024;
      drive(1'b1, b);
    end
    idle(8);

    do_reset(2);
    repeat (2 * R + 17) drive(1'b1, 1'b1);
    idle(3);
    do_reset(2);
    repeat (R + 8) drive(1'b1, 1'b1);
    idle(8);

    for (int k = 0; k < 2; k++) check($sformatf("drained_%0d", k), q[k].size(), 0);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
